sysbus_mem_responder: RTL and testbench

Burst memory responder for the `Sysbus` protocol, attached on the `Top` modport side. It accepts tagged read and write bursts from an initiator and serves them from an internal word-addressed RAM. It returns read data as tagged response beats. It serves as the on-chip memory target and as the bench-side memory model for `Sysbus` initiators.

---
 rtl/sysbus_mem_responder.sv | 141 ++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: burst memory target for the Sysbus protocol.
// Accepts tagged read/write bursts and serves them from an internal
// word-addressed RAM, returning read data as tagged response beats.
module sysbus_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int DEPTH      = 1024,
  parameter int BEATS      = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] req,
  input  logic [TAG_WIDTH-1:0]  reqtag,
  input  logic                  reqcyc,
  output logic                  reqack,
  output logic [DATA_WIDTH-1:0] resp,
  output logic [TAG_WIDTH-1:0]  resptag,
  output logic                  respcyc,
  input  logic                  respack
);

  localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [3:0]        TYPE_MEMORY = 4'b0001;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAST_WAIT   = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    RWAIT,
    RRESP
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [LAT_W-1:0]      lat_q;
  logic                  reqack_q;
  logic                  respcyc_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic [TAG_WIDTH-1:0]  resptag_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept_d;
  logic                  tagIsMem_d;
  logic [IDX_W-1:0]      beatAddr_d;
  logic [IDX_W-1:0]      nextAddr_d;
  logic                  memWe_d;

  // A beat can only be taken while no acknowledge pulse is outstanding,
  // which limits request throughput to one beat every two cycles.
  assign accept_d   = reqcyc & ~reqack_q;
  assign tagIsMem_d = (tag_q[TAG_WIDTH-2 -: 4] == TYPE_MEMORY);
  // Index arithmetic is IDX_W wide so bursts wrap from DEPTH-1 back to 0.
  assign beatAddr_d = idx_q + IDX_W'(beat_q);
  assign nextAddr_d = beatAddr_d + IDX_W'(1);
  assign memWe_d    = (state_q == WDATA) && accept_d && tagIsMem_d;

  assign reqack  = reqack_q;
  assign respcyc = respcyc_q;
  assign resp    = resp_q;
  assign resptag = resptag_q;

  // RAM write port; deliberately unreset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (memWe_d) begin
      mem_q[beatAddr_d] <= req;
    end
  end

  // Burst FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      reqack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            idx_q    <= req[OFF_W +: IDX_W];
            tag_q    <= reqtag;
            beat_q   <= '0;
            lat_q    <= '0;
            reqack_q <= 1'b1;
            state_q  <= reqtag[TAG_WIDTH-1] ? RWAIT : WDATA;
          end
        end
        WDATA: begin
          if (accept_d) begin
            reqack_q <= 1'b1;
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        RWAIT: begin
          if (lat_q == LAST_WAIT) begin
            state_q   <= RRESP;
            respcyc_q <= 1'b1;
            resptag_q <= tag_q;
            resp_q    <= tagIsMem_d ? mem_q[beatAddr_d] : '0;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        RRESP: begin
          if (respack) begin
            if (beat_q == LAST_BEAT) begin
              respcyc_q <= 1'b0;
              beat_q    <= '0;
              state_q   <= IDLE;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
              resp_q <= tagIsMem_d ? mem_q[nextAddr_d] : '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: directed bench for the Sysbus burst memory
// responder. Drives and samples on the falling clock edge.
module tb_sysbus_mem_responder;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] req;
  logic [TW-1:0] reqtag;
  logic          reqcyc;
  logic          reqack;
  logic [DW-1:0] resp;
  logic [TW-1:0] resptag;
  logic          respcyc;
  logic          respack;

  int assertCount = 0;
  int failCount   = 0;
  int ackPulses   = 0;
  int ackStart;

  logic [DW-1:0] expData [BEATS];

  sysbus_mem_responder #(
    .DATA_WIDTH(DW),
    .TAG_WIDTH(TW),
    .DEPTH(1024),
    .BEATS(BEATS),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .reqtag(reqtag),
    .reqcyc(reqcyc),
    .reqack(reqack),
    .resp(resp),
    .resptag(resptag),
    .respcyc(respcyc),
    .respack(respack)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Tally every cycle in which reqack is high.
  always @(negedge clk) begin
    if (reqack === 1'b1) ackPulses++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request beat and hold it until the acknowledge pulse.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [TW-1:0] t);
    int n;
    req    = d;
    reqtag = t;
    reqcyc = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (reqack !== 1'b1 && n < 20);
    checkOutput("reqackSeen", {63'b0, reqack}, 64'd1);
  endtask

  task automatic writeBurst(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input logic [DW-1:0] base);
    applyStimulus(addr, tag);
    for (int i = 0; i < BEATS; i++) applyStimulus(base + DW'(i), tag);
    reqcyc = 1'b0;
    req    = '0;
  endtask

  task automatic readBurst(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                           input int stallBeat, input int abortBeat);
    int n;
    applyStimulus(addr, tag);
    reqcyc = 1'b0;
    n = 0;
    while (respcyc !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("readLatency", 64'(n), 64'(LAT));
    for (int b = 0; b < BEATS; b++) begin
      if (b == abortBeat) begin
        #1 reset = 1'b0;
        #1;
        checkOutput("abortRespcyc", {63'b0, respcyc}, 64'd0);
        checkOutput("abortReqack", {63'b0, reqack}, 64'd0);
        checkOutput("abortResp", resp, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        return;
      end
      checkOutput($sformatf("respcyc[%0d]", b), {63'b0, respcyc}, 64'd1);
      checkOutput($sformatf("resp[%0d]", b), resp, expData[b]);
      checkOutput($sformatf("resptag[%0d]", b), 64'(resptag), 64'(tag));
      if (b == stallBeat) begin
        respack = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("stallRespcyc", {63'b0, respcyc}, 64'd1);
          checkOutput("stallResp", resp, expData[b]);
          checkOutput("stallResptag", 64'(resptag), 64'(tag));
        end
      end
      respack = 1'b1;
      @(negedge clk);
      respack = 1'b0;
    end
    checkOutput("respcycDrop", {63'b0, respcyc}, 64'd0);
  endtask

  // Directed test sequence.
  initial begin
    reset   = 1'b0;
    req     = '0;
    reqtag  = '0;
    reqcyc  = 1'b0;
    respack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReqack", {63'b0, reqack}, 64'd0);
    checkOutput("rstRespcyc", {63'b0, respcyc}, 64'd0);
    checkOutput("rstResp", resp, 64'd0);
    checkOutput("rstResptag", 64'(resptag), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Write 1..8 at 0x40 (index 8), count acknowledges, read back.
    ackStart = ackPulses;
    writeBurst(64'h40, 13'h0105, 64'h1);
    repeat (2) @(negedge clk);
    checkOutput("writeAckCount", 64'(ackPulses - ackStart), 64'd9);
    for (int i = 0; i < BEATS; i++) expData[i] = 64'(i + 1);
    readBurst(64'h40, 13'h1105, -1, -1);

    // Same read with respack withheld for three cycles on beat 2.
    readBurst(64'h40, 13'h1105, 2, -1);

    // Wrap: preload index 0..7, then burst from index DEPTH-2.
    writeBurst(64'h0, 13'h0101, 64'h50);
    writeBurst(64'h1FF0, 13'h0102, 64'hA0);
    for (int i = 0; i < BEATS; i++) expData[i] = 64'hA0 + 64'(i);
    readBurst(64'h1FF0, 13'h1102, -1, -1);
    // Aliased address with byte offset still maps to index 0.
    expData[0] = 64'hA2; expData[1] = 64'hA3; expData[2] = 64'hA4; expData[3] = 64'hA5;
    expData[4] = 64'hA6; expData[5] = 64'hA7; expData[6] = 64'h56; expData[7] = 64'h57;
    readBurst(64'h2003, 13'h1103, -1, -1);

    // Non-memory type: reads return zero, writes leave RAM alone.
    for (int i = 0; i < BEATS; i++) expData[i] = 64'h0;
    readBurst(64'h40, 13'h1405, -1, -1);
    writeBurst(64'h40, 13'h0405, 64'hDEAD0000);
    for (int i = 0; i < BEATS; i++) expData[i] = 64'(i + 1);
    readBurst(64'h40, 13'h1105, -1, -1);

    // Reset during response beat 3, then a clean read afterwards.
    readBurst(64'h40, 13'h1106, -1, 3);
    readBurst(64'h40, 13'h1107, -1, -1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
